// File: rtl/nor_flash_pkg.sv
// nor_flash_pkg: request mode codes, bridge FSM state encodings and a sizing helper shared by the NOR flash bridge files
package nor_flash_pkg;
  typedef enum logic [1:0] {MODE_RD = 2'b00, MODE_WR = 2'b01, MODE_WRPOLL = 2'b10, MODE_RSVD = 2'b11} mode_e;
  typedef enum logic [2:0] {S_RECOVER, S_IDLE, S_RD, S_WR_SU, S_WR_PL, S_WR_HD, S_POLL, S_DONE} state_e;
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/flash_wait_timer.sv
// flash_wait_timer: loadable down-counter shared by all timed bridge states; ports clk, start_i (load), load_i (value), done_o (count at 0)
module flash_wait_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         start_i,
  input  logic [W-1:0] load_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) cnt_q <= start_i ? load_i : cnt_q - W'(cnt_q != '0);
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/nor_flash_bridge.sv
// nor_flash_bridge: valid/ready request (read, write, write+STS poll) to timed registered NOR CE/OE/WE strobes; ports CLK_50MHZ/RST, req_*/rsp_* handshake, NF_* flash pins
module nor_flash_bridge
  import nor_flash_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int RD_WAIT     = 6,
  parameter int WR_SETUP    = 1,
  parameter int WR_PULSE    = 3,
  parameter int WR_HOLD     = 1,
  parameter int RP_RECOVER  = 8,
  parameter int STS_TIMEOUT = 1000
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              NF_CE,
  output logic              NF_OE,
  output logic              NF_WE,
  output logic              NF_RP,
  output logic              NF_WP,
  output logic              NF_BYTE,
  input  logic              NF_STS,
  output logic [ADDR_W-1:0] NF_A,
  inout  wire  [DATA_W-1:0] NF_D
);
  localparam int MAXC = max_u(max_u(max_u(RD_WAIT, WR_SETUP), max_u(WR_PULSE, WR_HOLD)), max_u(RP_RECOVER, STS_TIMEOUT));
  localparam int TW = $clog2(MAXC + 1);
  state_e state_q, state_d;
  mode_e mode_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0] sts_q, blank_q;
  logic [TW-1:0] tmr_load;
  logic drv_q, tmr_start, tmr_done, accept, timeout;
  assign accept = state_q == S_IDLE && req_valid;
  assign NF_D = drv_q ? wdata_q : 'z;
  assign NF_WP = 1'b0;
  assign NF_BYTE = DATA_W == 16;
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      S_RECOVER: state_d = tmr_done ? S_IDLE : S_RECOVER;
      S_IDLE: state_d = !req_valid ? S_IDLE : req_mode == MODE_RD ? S_RD : req_mode == MODE_RSVD ? S_DONE : S_WR_SU;
      S_RD: state_d = tmr_done ? S_DONE : S_RD;
      S_WR_SU: state_d = tmr_done ? S_WR_PL : S_WR_SU;
      S_WR_PL: state_d = tmr_done ? S_WR_HD : S_WR_PL;
      S_WR_HD: state_d = !tmr_done ? S_WR_HD : mode_q == MODE_WRPOLL ? S_POLL : S_DONE;
      S_POLL: begin
        timeout = !(blank_q == '0 && sts_q[1]) && tmr_done;
        state_d = (blank_q == '0 && sts_q[1]) || tmr_done ? S_DONE : S_POLL;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign tmr_start = RST || state_d != state_q;
  assign tmr_load = RST ? TW'(RP_RECOVER - 1) :
                    state_d == S_RD ? TW'(RD_WAIT - 1) :
                    state_d == S_WR_SU ? TW'(WR_SETUP - 1) :
                    state_d == S_WR_PL ? TW'(WR_PULSE - 1) :
                    state_d == S_WR_HD ? TW'(WR_HOLD - 1) :
                    state_d == S_POLL ? TW'(STS_TIMEOUT - 1) : '0;
  flash_wait_timer #(.W(TW)) u_timer (
    .clk(CLK_50MHZ),
    .start_i(tmr_start),
    .load_i(tmr_load),
    .done_o(tmr_done)
  );
  always_ff @(posedge CLK_50MHZ) sts_q <= {sts_q[0], NF_STS};
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_q <= S_RECOVER;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      NF_A <= '0;
      NF_CE <= 1'b1;
      NF_OE <= 1'b1;
      NF_WE <= 1'b1;
      NF_RP <= 1'b0;
      drv_q <= 1'b0;
      mode_q <= MODE_RD;
      wdata_q <= '0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      req_ready <= state_d == S_IDLE;
      rsp_valid <= state_d == S_DONE;
      NF_CE <= !(state_d inside {S_RD, S_WR_SU, S_WR_PL, S_WR_HD});
      NF_OE <= state_d != S_RD;
      NF_WE <= state_d != S_WR_PL;
      NF_RP <= 1'b1;
      drv_q <= state_d inside {S_WR_SU, S_WR_PL, S_WR_HD};
      blank_q <= state_q == S_POLL ? blank_q - 2'(blank_q != '0) : 2'd2;
      if (accept) begin
        NF_A <= req_addr;
        wdata_q <= req_wdata;
        mode_q <= mode_e'(req_mode);
        rsp_err <= req_mode == MODE_RSVD;
      end else if (timeout) rsp_err <= 1'b1;
      if (state_q == S_RD && tmr_done) rsp_rdata <= NF_D;
    end
  end
endmodule

// File: tb/tb_nor_flash_bridge.sv
// tb_nor_flash_bridge: directed plus random request sequence against a timing/contents reference model of the NOR flash bridge
module tb_nor_flash_bridge;
  localparam int RD_WAIT = 6, WR_SETUP = 1, WR_PULSE = 3, WR_HOLD = 1, RP_RECOVER = 8, STS_TIMEOUT = 1000;
  localparam int POLL_K = 1 + WR_SETUP + WR_PULSE + WR_HOLD;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, nf_sts = 1'b1;
  logic req_ready, rsp_valid, rsp_err, nf_ce, nf_oe, nf_we, nf_rp, nf_wp, nf_byte;
  logic [1:0] req_mode = 2'd0;
  logic [7:0] req_addr = 8'd0, req_wdata = 8'd0, rsp_rdata, nf_a;
  tri [7:0] nf_d;
  logic [7:0] mem [256];
  logic [7:0] rdata_exp = 8'd0;
  int n_cmp = 0, n_err = 0;
  always #10 clk = ~clk;
  assign nf_d = (!nf_ce && !nf_oe) ? mem[nf_a] : 'z;
  nor_flash_bridge dut (
    .CLK_50MHZ(clk), .RST(rst), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .NF_CE(nf_ce), .NF_OE(nf_oe), .NF_WE(nf_we), .NF_RP(nf_rp), .NF_WP(nf_wp), .NF_BYTE(nf_byte),
    .NF_STS(nf_sts), .NF_A(nf_a), .NF_D(nf_d)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_ready();
    int k;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_req", req_ready, 1);
  endtask
  task automatic recover_check();
    int cnt;
    rst = 1'b0;
    @(negedge clk);
    chk("rp_released", nf_rp, 1);
    cnt = 1;
    while (!req_ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("recover_cycles", cnt, RP_RECOVER);
  endtask
  task automatic txn(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] d, input int sts_k);
    int k, oe_lo, we_lo, drv, both, bad_a, lat_exp, xk;
    bit seen, err_exp;
    wait_ready();
    req_valid = 1'b1; req_mode = mode; req_addr = a; req_wdata = d; nf_sts = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_mode = 2'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
    k = 1; seen = 0; oe_lo = 0; we_lo = 0; drv = 0; both = 0; bad_a = 0;
    while (!seen && k < 2000) begin
      if (k == sts_k) nf_sts = 1'b1;
      oe_lo += int'(!nf_oe);
      we_lo += int'(!nf_we);
      both += int'(!nf_oe && !nf_we);
      drv += int'(nf_d === d);
      bad_a += int'(!nf_ce && nf_a !== a);
      if (rsp_valid) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    err_exp = 0;
    case (mode)
      2'd0: lat_exp = 1 + RD_WAIT + 1;
      2'd1: lat_exp = 1 + WR_SETUP + WR_PULSE + WR_HOLD + 1;
      2'd3: begin lat_exp = 2; err_exp = 1; end
      default: begin
        xk = sts_k <= 0 ? 1 << 20 : (sts_k + 2 > POLL_K + 2 ? sts_k + 2 : POLL_K + 2);
        if (xk <= POLL_K + STS_TIMEOUT - 1) lat_exp = xk + 2;
        else begin lat_exp = POLL_K + STS_TIMEOUT + 1; err_exp = 1; end
      end
    endcase
    if (mode == 2'd0) rdata_exp = mem[a];
    chk("rsp_seen", seen, 1);
    chk("latency", k + 1, lat_exp);
    chk("rsp_err", rsp_err, err_exp);
    chk("rsp_rdata", rsp_rdata, rdata_exp);
    chk("oe_low_cycles", oe_lo, mode == 2'd0 ? RD_WAIT : 0);
    chk("we_low_cycles", we_lo, mode inside {2'd1, 2'd2} ? WR_PULSE : 0);
    chk("oe_we_overlap", both, 0);
    chk("addr_stable", bad_a, 0);
    if (mode inside {2'd1, 2'd2}) chk("data_drive_cycles", drv, WR_SETUP + WR_PULSE + WR_HOLD);
    chk("done_ce_high", nf_ce, 1);
    chk("done_bus_released", nf_d === d && mode != 2'd0, 0);
    chk("done_not_ready", req_ready, 0);
    @(negedge clk);
    chk("rsp_single_pulse", rsp_valid, 0);
    chk("ready_after_rsp", req_ready, 1);
    if (mode inside {2'd1, 2'd2}) mem[a] = d;
  endtask
  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
  initial begin
    int k, pulses;
    logic [1:0] m;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h3C] = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_ce", nf_ce, 1);
    chk("rst_oe", nf_oe, 1);
    chk("rst_we", nf_we, 1);
    chk("rst_rp", nf_rp, 0);
    chk("rst_wp", nf_wp, 0);
    chk("rst_byte", nf_byte, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_addr", nf_a, 0);
    recover_check();
    txn(2'd0, 8'h3C, 8'h11, 0);
    txn(2'd1, 8'h10, 8'h5A, 0);
    txn(2'd0, 8'h10, 8'h22, 0);
    txn(2'd2, 8'h20, 8'h66, POLL_K + 50);
    txn(2'd2, 8'h21, 8'h67, 0);
    txn(2'd3, 8'h30, 8'h44, 0);
    txn(2'd2, 8'h22, 8'h68, 1);
    for (int i = 0; i < 14; i++) begin
      m = 2'($urandom_range(0, 3));
      txn(m, 8'($urandom), 8'($urandom_range(1, 254)), m == 2'd2 ? int'($urandom_range(1, 70)) : 0);
    end
    wait_ready();
    req_valid = 1'b1; req_mode = 2'd1; req_addr = 8'h77; req_wdata = 8'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (nf_we && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("we_fell_before_abort", nf_we, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we", nf_we, 1);
    chk("abort_ce", nf_ce, 1);
    chk("abort_rp", nf_rp, 0);
    chk("abort_bus_released", nf_d === 8'h3C, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    rdata_exp = 8'd0;
    pulses = 0;
    fork
      begin
        recover_check();
      end
      begin
        repeat (12) begin
          @(negedge clk);
          pulses += int'(rsp_valid);
        end
      end
    join
    chk("abort_no_rsp", pulses, 0);
    txn(2'd0, 8'h3C, 8'h01, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
